// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and external-memory signals around the memory port arbiter.
// The master side is the arbiter. The slave side is the pipeline stages plus memory.
interface mem_port_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_done;
  logic [15:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic        d_byte;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic        d_done;
  logic [15:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_done, i_rdata, i_err, d_done, d_rdata, d_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_byte, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_done, i_rdata, i_err, d_done, d_rdata, d_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 16-bit memory port between instruction fetch and data accesses.
// Data has priority, but fetch is forced in after a bounded streak of data grants.
//
// Handshake: i_req and d_req are held until their one-cycle done pulse. mem_req is
// held with stable mem_* until mem_ack is sampled high, or until the timeout expires.
module mem_port_arbiter #(
  parameter int FAIR_LIMIT = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master bus,
  output logic               busy,
  output logic [1:0]         dbg_state
);
  localparam int SW = $clog2(FAIR_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, I_BUSY = 2'd1, D_BUSY = 2'd2, RESP = 2'd3} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] streak;
  logic [TW-1:0] timer;
  logic          sel_d, we_q, byte_q, lane_hi_q;
  logic [1:0]    be_q;
  logic [15:0]   addr_q, wdata_q;
  logic [15:0]   i_rdata_q, d_rdata_q;
  logic          i_err_q, d_err_q;
  logic          i_v, d_v, grant_i, grant_d, mis_i, mis_d, timed_out;
  logic [15:0]   steered;

  always_comb begin
    i_v       = bus.i_req & ~bus.i_done;
    d_v       = bus.d_req & ~bus.d_done;
    grant_d   = d_v & (~i_v | (streak != SW'(FAIR_LIMIT)));
    grant_i   = i_v & ~grant_d;
    mis_i     = bus.i_addr[0];
    mis_d     = ~bus.d_byte & bus.d_addr[0];
    timed_out = (timer == TW'(TIMEOUT - 1));
    steered   = byte_q ? {8'h00, (lane_hi_q ? bus.mem_rdata[15:8] : bus.mem_rdata[7:0])}
                       : bus.mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = mis_d ? RESP : D_BUSY;
        else if (grant_i) state_nxt = mis_i ? RESP : I_BUSY;
      end
      I_BUSY, D_BUSY: if (bus.mem_ack || timed_out) state_nxt = RESP;
      RESP:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req   = (state == I_BUSY) || (state == D_BUSY);
    bus.mem_we    = we_q;
    bus.mem_be    = be_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.i_done    = (state == RESP) && !sel_d;
    bus.d_done    = (state == RESP) && sel_d;
    bus.i_rdata   = i_rdata_q;
    bus.i_err     = i_err_q;
    bus.d_rdata   = d_rdata_q;
    bus.d_err     = d_err_q;
    busy          = (state != IDLE);
    dbg_state     = state;
  end

  // Response data is only written on the edge that enters RESP, so it stays put
  // from one done pulse to the next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak    <= '0;
      timer     <= '0;
      sel_d     <= 1'b0;
      we_q      <= 1'b0;
      byte_q    <= 1'b0;
      lane_hi_q <= 1'b0;
      be_q      <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      i_err_q   <= 1'b0;
      d_rdata_q <= '0;
      d_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (grant_d && bus.i_req) begin
            if (streak != SW'(FAIR_LIMIT)) streak <= streak + 1'b1;
          end else if (grant_i || !bus.i_req) begin
            streak <= '0;
          end
          if (grant_d) begin
            sel_d     <= 1'b1;
            addr_q    <= {bus.d_addr[15:1], 1'b0};
            we_q      <= bus.d_we;
            byte_q    <= bus.d_byte;
            lane_hi_q <= bus.d_addr[0];
            be_q      <= bus.d_byte ? (bus.d_addr[0] ? 2'b10 : 2'b01) : 2'b11;
            wdata_q   <= bus.d_byte ? {2{bus.d_wdata[7:0]}} : bus.d_wdata;
            if (mis_d) begin
              d_rdata_q <= '0;
              d_err_q   <= 1'b1;
            end
          end else if (grant_i) begin
            sel_d     <= 1'b0;
            addr_q    <= {bus.i_addr[15:1], 1'b0};
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            lane_hi_q <= 1'b0;
            be_q      <= 2'b11;
            if (mis_i) begin
              i_rdata_q <= '0;
              i_err_q   <= 1'b1;
            end
          end
        end
        I_BUSY, D_BUSY: begin
          timer <= timer + 1'b1;
          if (bus.mem_ack) begin
            if (sel_d) begin
              d_rdata_q <= steered;
              d_err_q   <= 1'b0;
            end else begin
              i_rdata_q <= bus.mem_rdata;
              i_err_q   <= 1'b0;
            end
          end else if (timed_out) begin
            if (sel_d) begin
              d_rdata_q <= '0;
              d_err_q   <= 1'b1;
            end else begin
              i_rdata_q <= '0;
              i_err_q   <= 1'b1;
            end
          end
        end
        default: timer <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand-written fairness, timeout and mid-transaction reset sequences.
module tb_mem_port_arbiter;
  localparam int FL = 4;
  localparam int TO = 8;

  typedef struct {
    logic        is_d, we, byt;
    logic [15:0] addr, wdata, mrdata;
    int          wait_n;
    logic        exp_mem;
    logic [15:0] exp_addr;
    logic [1:0]  exp_be;
    logic [15:0] exp_wdata, exp_rdata;
    logic        exp_err, chk_rdata;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       busy;
  logic [1:0] dbg_state;
  int         n_checks = 0;
  int         n_fail = 0;
  logic       ack_en = 1'b1;
  logic       stray = 1'b0;
  int         wait_n = 0;
  vec_t       vecs[10];

  always #5 clk = ~clk;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.FAIR_LIMIT(FL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .dbg_state(dbg_state)
  );

  // Memory model: acks after wait_n cycles of mem_req, or strays an ack on request.
  initial begin
    int req_cnt;
    req_cnt = 0;
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        bus.mem_ack = ack_en && (req_cnt >= wait_n);
        req_cnt++;
      end else begin
        bus.mem_ack = 1'b0;
        req_cnt = 0;
      end
      if (stray) bus.mem_ack = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic is_d, we, byt, input logic [15:0] addr, wdata, mrdata,
                              input int wn, input logic em, input logic [15:0] ea,
                              input logic [1:0] ebe, input logic [15:0] ewd, erd,
                              input logic eerr, crd);
    vec_t v;
    v.is_d = is_d; v.we = we; v.byt = byt; v.addr = addr; v.wdata = wdata; v.mrdata = mrdata;
    v.wait_n = wn; v.exp_mem = em; v.exp_addr = ea; v.exp_be = ebe; v.exp_wdata = ewd;
    v.exp_rdata = erd; v.exp_err = eerr; v.chk_rdata = crd;
    return v;
  endfunction

  task automatic do_txn(input vec_t v, input string nm);
    bit saw_mem, got;
    saw_mem = 0;
    got = 0;
    wait_n = v.wait_n;
    bus.mem_rdata = v.mrdata;
    @(negedge clk);
    if (v.is_d) begin
      bus.d_we = v.we; bus.d_byte = v.byt; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
      bus.d_req = 1'b1;
    end else begin
      bus.i_addr = v.addr;
      bus.i_req = 1'b1;
    end
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      if (bus.mem_req && !saw_mem) begin
        saw_mem = 1;
        chk({nm, "_mem_addr"}, 32'(bus.mem_addr), 32'(v.exp_addr));
        chk({nm, "_mem_be"}, 32'(bus.mem_be), 32'(v.exp_be));
        chk({nm, "_mem_we"}, 32'(bus.mem_we), 32'(v.we));
        if (v.we) chk({nm, "_mem_wdata"}, 32'(bus.mem_wdata), 32'(v.exp_wdata));
      end
      if (v.is_d ? bus.d_done : bus.i_done) begin
        got = 1;
        chk({nm, "_other_done"}, 32'(v.is_d ? bus.i_done : bus.d_done), 32'd0);
        if (v.chk_rdata)
          chk({nm, "_rdata"}, 32'(v.is_d ? bus.d_rdata : bus.i_rdata), 32'(v.exp_rdata));
        chk({nm, "_err"}, 32'(v.is_d ? bus.d_err : bus.i_err), 32'(v.exp_err));
        chk({nm, "_used_mem"}, 32'(saw_mem), 32'(v.exp_mem));
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
      end
    end
    if (!got) begin
      chk({nm, "_done_timeout"}, 32'd0, 32'd1);
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
    end
  endtask

  initial begin
    int         n, cnt, dd_cnt;
    bit         seen;
    logic [9:0] seq;

    vecs[0] = mk(0, 0, 0, 16'h0010, 16'h0000, 16'hA5C3, 0, 1, 16'h0010, 2'b11, 16'h0000, 16'hA5C3, 0, 1);
    vecs[1] = mk(1, 1, 1, 16'h0021, 16'h1234, 16'h0000, 0, 1, 16'h0020, 2'b10, 16'h3434, 16'h0000, 0, 0);
    vecs[2] = mk(1, 0, 1, 16'h0021, 16'h0000, 16'hBEEF, 0, 1, 16'h0020, 2'b10, 16'h0000, 16'h00BE, 0, 1);
    vecs[3] = mk(1, 0, 1, 16'h0020, 16'h0000, 16'hBEEF, 2, 1, 16'h0020, 2'b01, 16'h0000, 16'h00EF, 0, 1);
    vecs[4] = mk(1, 1, 0, 16'h0042, 16'hCAFE, 16'h0000, 1, 1, 16'h0042, 2'b11, 16'hCAFE, 16'h0000, 0, 0);
    vecs[5] = mk(1, 0, 0, 16'h0044, 16'h0000, 16'h1357, 1, 1, 16'h0044, 2'b11, 16'h0000, 16'h1357, 0, 1);
    vecs[6] = mk(1, 0, 0, 16'h0003, 16'h0000, 16'hFFFF, 0, 0, 16'h0000, 2'b00, 16'h0000, 16'h0000, 1, 1);
    vecs[7] = mk(0, 0, 0, 16'h0011, 16'h0000, 16'hFFFF, 0, 0, 16'h0000, 2'b00, 16'h0000, 16'h0000, 1, 1);
    vecs[8] = mk(1, 1, 1, 16'h0030, 16'hABCD, 16'h0000, 0, 1, 16'h0030, 2'b01, 16'hCDCD, 16'h0000, 0, 0);
    vecs[9] = mk(1, 0, 1, 16'h0003, 16'h0000, 16'h5A00, 3, 1, 16'h0002, 2'b10, 16'h0000, 16'h005A, 0, 1);

    // clock/reset
    rst_n = 1'b0;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_byte = 0;
    bus.d_addr = 0; bus.d_wdata = 0; bus.mem_rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_state", 32'(dbg_state), 0);
    chk("rst_dones", 32'({bus.i_done, bus.d_done}), 0);
    chk("rst_rdata", 32'({bus.i_rdata, bus.d_rdata}), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    rst_n = 1'b1;

    // fetch latency: mem_req one cycle after req, done on the third
    wait_n = 0;
    bus.mem_rdata = 16'hA5C3;
    @(negedge clk);
    bus.i_addr = 16'h0010;
    bus.i_req = 1'b1;
    @(negedge clk);
    chk("lat_mem_req", 32'(bus.mem_req), 1);
    chk("lat_early_done", 32'(bus.i_done), 0);
    @(negedge clk);
    chk("lat_i_done", 32'(bus.i_done), 1);
    chk("lat_i_rdata", 32'(bus.i_rdata), 32'h0000A5C3);
    chk("lat_i_err", 32'(bus.i_err), 0);
    bus.i_req = 1'b0;

    for (int k = 0; k < 10; k++) do_txn(vecs[k], $sformatf("vec%0d", k));

    // fairness with both requesters held
    @(negedge clk);
    wait_n = 0;
    bus.mem_rdata = 16'h1111;
    bus.i_addr = 16'h0010;
    bus.d_addr = 16'h0040; bus.d_we = 0; bus.d_byte = 0;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    n = 0;
    seq = '0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge clk);
      if (bus.d_done || bus.i_done) begin
        seq = {seq[8:0], bus.d_done};
        n++;
      end
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    chk("fair_count", 32'(n), 32'd10);
    chk("fair_order", 32'(seq), 32'(10'b1111011110));

    // timeout: no ack ever
    @(negedge clk);
    ack_en = 1'b0;
    bus.i_addr = 16'h0010;
    bus.i_req = 1'b1;
    cnt = 0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (bus.mem_req) cnt++;
      if (bus.i_done) begin
        seen = 1;
        chk("to_i_err", 32'(bus.i_err), 1);
        chk("to_i_rdata", 32'(bus.i_rdata), 0);
        bus.i_req = 1'b0;
      end
    end
    bus.i_req = 1'b0;
    chk("to_seen_done", 32'(seen), 1);
    chk("to_req_cycles", 32'(cnt), 32'(TO));
    stray = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_state", 32'(dbg_state), 0);
    chk("stray_dones", 32'({bus.i_done, bus.d_done}), 0);
    stray = 1'b0;
    ack_en = 1'b1;
    do_txn(vecs[0], "after_to");

    // reset while D_BUSY
    wait_n = 20;
    @(negedge clk);
    bus.d_addr = 16'h0040; bus.d_we = 0; bus.d_byte = 0;
    bus.d_req = 1'b1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (dbg_state == 2'd2) seen = 1;
    end
    chk("rb_reached_dbusy", 32'(seen), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rb_mem_req", 32'(bus.mem_req), 0);
    chk("rb_busy", 32'(busy), 0);
    chk("rb_state", 32'(dbg_state), 0);
    bus.d_req = 1'b0;
    dd_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.d_done) dd_cnt++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.d_done) dd_cnt++;
    end
    chk("rb_no_done", 32'(dd_cnt), 0);
    do_txn(vecs[5], "after_rst");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
